regfile_scoreboard: RTL and testbench

Parametrised register file for the RISC-V core with N combinational read ports, one write-back port, same-cycle write-to-read bypass, and a per-register busy scoreboard. Decode reads operands and marks a destination busy at issue; write-back clears the mark. Hazard logic uses the per-port busy flags and the busy count to stall. Register 0 is optionally hardwired to zero.

---
 rtl/regfile_scoreboard.sv | 97 +++++++++
 tb/tb_regfile_scoreboard.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with combinational read ports, one write-back port with same-cycle
// bypass, and a per-register busy scoreboard with a registered busy count.
module regfile_scoreboard #(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 32,
    parameter int AW         = 5,
    parameter int READ_PORTS = 2,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [READ_PORTS*AW-1:0]     rd_addr,
    output logic [READ_PORTS*DATA_W-1:0] rd_data,
    output logic [READ_PORTS-1:0]        rd_busy,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         issue_en,
    input  logic [AW-1:0]                issue_addr,
    input  logic                         flush,
    output logic [AW:0]                  busy_count
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                wr_ok;
    logic                iss_ok;

    // Out-of-range addresses and (optionally) x0 are treated as non-existent.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        addr_ok = (32'(a) < 32'(NUM_REGS)) && !(ZERO_REG && (a == '0));
    endfunction

    function automatic logic [AW:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            c = c + (AW+1)'(v[i]);
        end
        return c;
    endfunction

    assign wr_ok  = wr_en && addr_ok(wr_addr);
    assign iss_ok = issue_en && addr_ok(issue_addr);

    // Issue beats flush beats write-back: a newly issued producer owns the register.
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (iss_ok && (issue_addr == AW'(i))) begin
                busy_nxt[i] = 1'b1;
            end else if (flush) begin
                busy_nxt[i] = 1'b0;
            end else if (wr_ok && (wr_addr == AW'(i))) begin
                busy_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_count <= popcount(busy_nxt);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Reads are forced to zero while reset is held so an in-flight write cannot leak through the bypass.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            if (rst && addr_ok(rd_addr[p*AW +: AW])) begin
                if (wr_en && (wr_addr == rd_addr[p*AW +: AW])) begin
                    rd_data[p*DATA_W +: DATA_W] = wr_data;
                end else begin
                    rd_data[p*DATA_W +: DATA_W] = regs[rd_addr[p*AW +: AW]];
                    rd_busy[p]                  = busy[rd_addr[p*AW +: AW]];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a cycle-by-cycle vector table on the default
// configuration plus hand sequences for reset and a 24-register, 3-port, no-x0 instance.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;

    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        flush;
    logic [5:0]  busy_count;

    logic [14:0] rd_addr2;
    logic [95:0] rd_data2;
    logic [2:0]  rd_busy2;
    logic        wr_en2;
    logic [4:0]  wr_addr2;
    logic [31:0] wr_data2;
    logic        issue_en2;
    logic [4:0]  issue_addr2;
    logic        flush2;
    logic [5:0]  busy_count2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush),
        .busy_count(busy_count)
    );

    regfile_scoreboard #(
        .DATA_W(32), .NUM_REGS(24), .AW(5), .READ_PORTS(3), .ZERO_REG(1'b0)
    ) dut2 (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_busy(rd_busy2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .issue_en(issue_en2), .issue_addr(issue_addr2), .flush(flush2),
        .busy_count(busy_count2)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ie;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic [5:0]  ec;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ia, input logic fl,
                       input logic [4:0] r0, input logic [4:0] r1,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic [1:0] eb, input logic [5:0] ec);
        vec_t v;
        v = '{we, wa, wd, ie, ia, fl, r0, r1, e0, e1, eb, ec};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
        wr_en2 = 1'b0; wr_addr2 = '0; wr_data2 = '0;
        issue_en2 = 1'b0; issue_addr2 = '0; flush2 = 1'b0;
    endtask

    initial begin
        // Each row is one clock cycle: inputs held for the cycle, outputs sampled mid-cycle.
        //  we wa  wd            ie ia  fl  r0  r1   e0            e1            eb     ec
        add(0, 0,  32'h0,        0, 0,  0,  5,  7,   32'h0,        32'h0,        2'b00, 0);
        add(1, 5,  32'hDEADBEEF, 0, 0,  0,  5,  0,   32'hDEADBEEF, 32'h0,        2'b00, 0);
        add(0, 0,  32'h0,        0, 0,  0,  5,  5,   32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0);
        add(1, 0,  32'hFFFFFFFF, 0, 0,  0,  0,  5,   32'h0,        32'hDEADBEEF, 2'b00, 0);
        add(0, 0,  32'h0,        1, 7,  0,  0,  7,   32'h0,        32'h0,        2'b00, 0);
        add(0, 0,  32'h0,        0, 0,  0,  5,  7,   32'hDEADBEEF, 32'h0,        2'b10, 1);
        add(1, 7,  32'h1234,     0, 0,  0,  7,  7,   32'h1234,     32'h1234,     2'b00, 1);
        add(0, 0,  32'h0,        0, 0,  0,  7,  7,   32'h1234,     32'h1234,     2'b00, 0);
        add(1, 9,  32'hAA,       1, 9,  0,  9,  7,   32'hAA,       32'h1234,     2'b00, 0);
        add(0, 0,  32'h0,        0, 0,  0,  9,  7,   32'hAA,       32'h1234,     2'b01, 1);
        add(1, 1,  32'h11,       0, 0,  0,  1,  9,   32'h11,       32'hAA,       2'b10, 1);
        add(1, 2,  32'h22,       1, 1,  0,  2,  1,   32'h22,       32'h11,       2'b00, 1);
        add(1, 3,  32'h33,       1, 2,  0,  1,  3,   32'h11,       32'h33,       2'b01, 2);
        add(0, 0,  32'h0,        1, 3,  0,  2,  9,   32'h22,       32'hAA,       2'b11, 3);
        add(0, 0,  32'h0,        1, 4,  1,  3,  1,   32'h33,       32'h11,       2'b11, 4);
        add(0, 0,  32'h0,        0, 0,  0,  4,  1,   32'h0,        32'h11,       2'b01, 1);
        add(0, 0,  32'h0,        1, 0,  0,  2,  3,   32'h22,       32'h33,       2'b00, 1);
        add(0, 0,  32'h0,        0, 0,  0,  0,  4,   32'h0,        32'h0,        2'b10, 1);
        add(1, 4,  32'h44,       0, 0,  1,  4,  2,   32'h44,       32'h22,       2'b00, 1);
        add(0, 0,  32'h0,        0, 0,  0,  4,  2,   32'h44,       32'h22,       2'b00, 0);

        // Reset held while a write and an issue are requested.
        rst = 1'b0;
        idle_inputs();
        wr_en = 1'b1; wr_addr = 5; wr_data = 32'hFF;
        issue_en = 1'b1; issue_addr = 6;
        rd_addr = {5'd6, 5'd5};
        wr_en2 = 1'b1; wr_addr2 = 5; wr_data2 = 32'hFF;
        issue_en2 = 1'b1; issue_addr2 = 6;
        rd_addr2 = {5'd6, 5'd5, 5'd5};
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset_rd_data", rd_data, 64'h0);
        check("reset_rd_busy", 64'(rd_busy), 64'h0);
        check("reset_busy_count", 64'(busy_count), 64'h0);
        check("reset_busy_count2", 64'(busy_count2), 64'h0);
        check("reset_rd_data2", rd_data2[63:0], 64'h0);

        rst = 1'b1;
        idle_inputs();
        for (int a = 0; a < 32; a++) begin
            rd_addr = {a[4:0], a[4:0]};
            #1;
            check($sformatf("post_reset_data_x%0d", a), rd_data, 64'h0);
            check($sformatf("post_reset_busy_x%0d", a), 64'(rd_busy), 64'h0);
        end
        check("post_reset_busy_count", 64'(busy_count), 64'h0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            issue_en = vecs[i].ie; issue_addr = vecs[i].ia; flush = vecs[i].fl;
            rd_addr = {vecs[i].r1, vecs[i].r0};
            @(negedge clk);
            check($sformatf("row%0d_rd_data0", i), 64'(rd_data[31:0]), 64'(vecs[i].e0));
            check($sformatf("row%0d_rd_data1", i), 64'(rd_data[63:32]), 64'(vecs[i].e1));
            check($sformatf("row%0d_rd_busy", i), 64'(rd_busy), 64'(vecs[i].eb));
            check($sformatf("row%0d_busy_count", i), 64'(busy_count), 64'(vecs[i].ec));
            @(posedge clk);
            #1;
        end

        // Reset asserted between edges clears state without a clock.
        idle_inputs();
        issue_en = 1'b1; issue_addr = 10;
        rd_addr = {5'd10, 5'd5};
        @(posedge clk);
        #1;
        issue_en = 1'b0;
        check("midreset_pre_count", 64'(busy_count), 64'd1);
        check("midreset_pre_busy", 64'(rd_busy), 64'b10);
        #2;
        rst = 1'b0;
        #1;
        check("midreset_count", 64'(busy_count), 64'd0);
        check("midreset_rd_data", rd_data, 64'h0);
        check("midreset_rd_busy", 64'(rd_busy), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_after_x5", 64'(rd_data[31:0]), 64'h0);
        check("midreset_after_busy", 64'(rd_busy), 64'h0);

        // 24 registers, 3 ports, x0 writable.
        @(posedge clk);
        #1;
        rd_addr2 = {5'd30, 5'd23, 5'd0};
        wr_en2 = 1'b1; wr_addr2 = 0; wr_data2 = 32'h100;
        @(negedge clk);
        check("p_x0_bypass", 64'(rd_data2[31:0]), 64'h100);
        @(posedge clk);
        #1;
        wr_addr2 = 23; wr_data2 = 32'h2300;
        @(negedge clk);
        check("p_x23_bypass", 64'(rd_data2[63:32]), 64'h2300);
        check("p_x0_stored", 64'(rd_data2[31:0]), 64'h100);
        @(posedge clk);
        #1;
        wr_addr2 = 30; wr_data2 = 32'hFFFF;
        issue_en2 = 1'b1; issue_addr2 = 30;
        @(negedge clk);
        check("p_x30_no_bypass", 64'(rd_data2[95:64]), 64'h0);
        check("p_x30_write_busy", 64'(rd_busy2), 64'h0);
        @(posedge clk);
        #1;
        wr_en2 = 1'b0;
        issue_en2 = 1'b1; issue_addr2 = 0;
        @(negedge clk);
        check("p_port0", 64'(rd_data2[31:0]), 64'h100);
        check("p_port1", 64'(rd_data2[63:32]), 64'h2300);
        check("p_port2_x30", 64'(rd_data2[95:64]), 64'h0);
        check("p_busy_none", 64'(rd_busy2), 64'h0);
        check("p_count_zero", 64'(busy_count2), 64'd0);
        @(posedge clk);
        #1;
        issue_en2 = 1'b0;
        @(negedge clk);
        check("p_busy_x0", 64'(rd_busy2), 64'b001);
        check("p_count_x0", 64'(busy_count2), 64'd1);
        check("p_port2_x30_after", 64'(rd_data2[95:64]), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
